// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_pkg                                                      |
// | Description : Shared types and encodings for the memory arbiter slice.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mem_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Access size encodings shared with the memory and the load/store unit.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Requester identity.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_align_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_align_check                                              |
// | Description : Flags misaligned or invalid-size memory accesses.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_align_check
  import mem_pkg::*;
(
  input  logic [1:0] addr_lo_i,
  input  logic [1:0] size_i,
  output logic       err_o
);

  // Halves need an even address, words a 4-byte aligned one; size 11 is never legal.
  always_comb begin
    err_o = 1'b0;
    case (size_i)
      SIZE_BYTE: err_o = 1'b0;
      SIZE_HALF: err_o = addr_lo_i[0];
      SIZE_WORD: err_o = |addr_lo_i;
      default:   err_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                  |
// | Description : Round-robin arbiter/sequencer sharing one data memory port   |
// |               between instruction fetch and the load/store unit.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_sign,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic        mem_sign,
  input  logic [31:0] mem_dout
);

  localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic        err_q, err_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        sel_own;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic        sel_sign;
  logic        sel_err;

  // Pick the winner: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    sel_own = OWN_IF;
    if (if_req && d_req) begin
      sel_own = ~last_owner_q;
    end else if (d_req) begin
      sel_own = OWN_D;
    end
    sel_addr  = (sel_own == OWN_D) ? d_addr  : if_addr;
    sel_wdata = (sel_own == OWN_D) ? d_wdata : 32'h0;
    sel_we    = (sel_own == OWN_D) ? d_we    : 1'b0;
    sel_size  = (sel_own == OWN_D) ? d_size  : SIZE_WORD;
    sel_sign  = (sel_own == OWN_D) ? d_sign  : 1'b0;
  end

  // The winner is checked before grant so a bad access can bypass BUSY entirely.
  mem_align_check u_align (
    .addr_lo_i (sel_addr[1:0]),
    .size_i    (sel_size),
    .err_o     (sel_err)
  );

  // Next-state logic: grant in IDLE, count down in BUSY, single response cycle in RESP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    size_d       = size_q;
    sign_d       = sign_q;
    err_d        = err_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          owner_d      = sel_own;
          last_owner_d = sel_own;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          we_d         = sel_we;
          size_d       = sel_size;
          sign_d       = sel_sign;
          err_d        = sel_err;
          cnt_d        = LAST_CNT;
          if (sel_err) begin
            // A rejected access completes with zero data.
            state_d = RESP;
            if (sel_own == OWN_D) begin
              d_rdata_d = 32'h0;
            end else begin
              if_rdata_d = 32'h0;
            end
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (!we_q) begin
            if (owner_q == OWN_D) begin
              d_rdata_d = mem_dout;
            end else begin
              if_rdata_d = mem_dout;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_D;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      sign_q       <= 1'b0;
      err_q        <= 1'b0;
      if_rdata_q   <= 32'h0;
      d_rdata_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      err_q        <= err_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Loads read on every BUSY cycle; stores write only on the last one.
  assign mem_read  = (state_q == BUSY) && !we_q;
  assign mem_write = (state_q == BUSY) && we_q && (cnt_q == 4'd0);
  assign mem_addr  = addr_q;
  assign mem_din   = wdata_q;
  assign mem_size  = size_q;
  assign mem_sign  = sign_q;

  assign if_ready = (state_q == RESP) && (owner_q == OWN_IF);
  assign d_ready  = (state_q == RESP) && (owner_q == OWN_D);
  assign if_err   = if_ready && err_q;
  assign d_err    = d_ready && err_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                               |
// | Description : Scoreboard bench for mem_arbiter at latencies 2, 3 and 1.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        if_req  [N];
  logic [31:0] if_addr [N];
  logic [31:0] if_rdata[N];
  logic        if_ready[N];
  logic        if_err  [N];
  logic        d_req   [N];
  logic [31:0] d_addr  [N];
  logic [31:0] d_wdata [N];
  logic        d_we    [N];
  logic [1:0]  d_size  [N];
  logic        d_sign  [N];
  logic [31:0] d_rdata [N];
  logic        d_ready [N];
  logic        d_err   [N];
  logic [31:0] mem_addr[N];
  logic [31:0] mem_din [N];
  logic        mem_read[N];
  logic        mem_write[N];
  logic [1:0]  mem_size[N];
  logic        mem_sign[N];
  logic [31:0] mem_dout[N];

  logic [7:0]  m [N][1024];
  int          rd_cnt[N];
  int          wr_cnt[N];
  logic [9:0]  ra;
  logic [9:0]  wa;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          inst;
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
    int          lat;
    int          nrd;
    int          nwr;
    bit          drop;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT_G = (g == 0) ? 2 : (g == 1) ? 3 : 1;
    mem_arbiter #(.MEM_LATENCY(LAT_G)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_rdata  (if_rdata[g]),
      .if_ready  (if_ready[g]),
      .if_err    (if_err[g]),
      .d_req     (d_req[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_we      (d_we[g]),
      .d_size    (d_size[g]),
      .d_sign    (d_sign[g]),
      .d_rdata   (d_rdata[g]),
      .d_ready   (d_ready[g]),
      .d_err     (d_err[g]),
      .mem_addr  (mem_addr[g]),
      .mem_din   (mem_din[g]),
      .mem_read  (mem_read[g]),
      .mem_write (mem_write[g]),
      .mem_size  (mem_size[g]),
      .mem_sign  (mem_sign[g]),
      .mem_dout  (mem_dout[g])
    );
  end

  function automatic logic [7:0] pb(input logic [9:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] exp_w(input logic [9:0] a);
    return {pb(a + 10'd3), pb(a + 10'd2), pb(a + 10'd1), pb(a)};
  endfunction

  // Memory model: combinational, size/sign aware reads.
  always_comb begin
    ra = 10'd0;
    for (int g = 0; g < N; g++) begin
      ra = mem_addr[g][9:0];
      case (mem_size[g])
        SIZE_BYTE: mem_dout[g] = {{24{mem_sign[g] & m[g][ra][7]}}, m[g][ra]};
        SIZE_HALF: mem_dout[g] = {{16{mem_sign[g] & m[g][ra + 10'd1][7]}},
                                  m[g][ra + 10'd1], m[g][ra]};
        default:   mem_dout[g] = {m[g][ra + 10'd3], m[g][ra + 10'd2],
                                  m[g][ra + 10'd1], m[g][ra]};
      endcase
    end
  end

  // Memory model: preload, then clocked writes and port-activity counters.
  initial begin
    for (int g = 0; g < N; g++) begin
      for (int i = 0; i < 1024; i++) m[g][i] = pb(10'(i));
      m[g][10'h40] = 8'h04;
      m[g][10'h41] = 8'h00;
      m[g][10'h42] = 8'h01;
      m[g][10'h43] = 8'h8C;
      rd_cnt[g] = 0;
      wr_cnt[g] = 0;
    end
    forever begin
      @(posedge clk);
      for (int g = 0; g < N; g++) begin
        if (mem_read[g]) rd_cnt[g]++;
        if (mem_write[g]) begin
          wr_cnt[g]++;
          wa = mem_addr[g][9:0];
          m[g][wa] = mem_din[g][7:0];
          if (mem_size[g] != SIZE_BYTE) m[g][wa + 10'd1] = mem_din[g][15:8];
          if (mem_size[g] == SIZE_WORD) begin
            m[g][wa + 10'd2] = mem_din[g][23:16];
            m[g][wa + 10'd3] = mem_din[g][31:24];
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue_if(input int g, input logic [31:0] addr, input logic [31:0] rdata,
                          input bit err, input int lat, input int nrd);
    exp_t e;
    if_addr[g] = addr;
    if_req[g]  = 1'b1;
    e = '{inst: g, is_d: 1'b0, rdata: rdata, err: err, lat: lat, nrd: nrd, nwr: 0, drop: 1'b1};
    sb.push_back(e);
  endtask

  task automatic issue_d(input int g, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] rdata, input bit err, input int lat,
                         input int nrd, input int nwr);
    exp_t e;
    d_addr[g]  = addr;
    d_wdata[g] = wdata;
    d_we[g]    = we;
    d_size[g]  = size;
    d_sign[g]  = sign;
    d_req[g]   = 1'b1;
    e = '{inst: g, is_d: 1'b1, rdata: rdata, err: err, lat: lat, nrd: nrd, nwr: nwr, drop: 1'b1};
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and wait (bounded) for its ready pulse.
  task automatic wait_resp(input string tag);
    exp_t e;
    int   n;
    int   rd0;
    int   wr0;
    logic rdy;
    e   = sb.pop_front();
    rd0 = rd_cnt[e.inst];
    wr0 = wr_cnt[e.inst];
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 40) begin
      tick();
      n++;
      rdy = e.is_d ? d_ready[e.inst] : if_ready[e.inst];
    end
    chk({tag, "_ready"}, 32'(rdy), 32'd1);
    chk({tag, "_latency"}, n, e.lat);
    if (e.is_d) begin
      chk({tag, "_rdata"}, d_rdata[e.inst], e.rdata);
      chk({tag, "_err"}, 32'(d_err[e.inst]), 32'(e.err));
      chk({tag, "_other_ready"}, 32'(if_ready[e.inst]), 32'd0);
    end else begin
      chk({tag, "_rdata"}, if_rdata[e.inst], e.rdata);
      chk({tag, "_err"}, 32'(if_err[e.inst]), 32'(e.err));
      chk({tag, "_other_ready"}, 32'(d_ready[e.inst]), 32'd0);
    end
    chk({tag, "_read_cycles"}, rd_cnt[e.inst] - rd0, e.nrd);
    chk({tag, "_writes"}, wr_cnt[e.inst] - wr0, e.nwr);
    if (e.drop) begin
      if (e.is_d) d_req[e.inst] = 1'b0;
      else        if_req[e.inst] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int wr0;
    exp_t e;
    for (int g = 0; g < N; g++) begin
      if_req[g] = 1'b0;  if_addr[g] = 32'h0;
      d_req[g]  = 1'b0;  d_addr[g]  = 32'h0;  d_wdata[g] = 32'h0;
      d_we[g]   = 1'b0;  d_size[g]  = 2'b00;  d_sign[g]  = 1'b0;
    end
    rst = 1'b1;
    repeat (3) tick();

    // Reset state.
    chk("rst_if_ready", 32'(if_ready[0]), 32'd0);
    chk("rst_d_ready",  32'(d_ready[0]),  32'd0);
    chk("rst_errs",     32'({if_err[0], d_err[0]}), 32'd0);
    chk("rst_if_rdata", if_rdata[0], 32'h0);
    chk("rst_d_rdata",  d_rdata[0],  32'h0);
    chk("rst_mem_rw",   32'({mem_read[0], mem_write[0]}), 32'd0);
    chk("rst_mem_addr", mem_addr[0], 32'h0);
    chk("rst_mem_din",  mem_din[0],  32'h0);
    chk("rst_mem_ctl",  32'({mem_size[0], mem_sign[0]}), 32'd0);
    rst = 1'b0;
    tick();

    // Fetch alone, latency 2.
    issue_if(0, 32'h40, 32'h8C010004, 1'b0, 3, 2);
    wait_resp("fetch40");
    tick();

    // Byte store, then signed/unsigned loads of it.
    issue_d(0, 32'h13, 32'h123456A5, 1'b1, SIZE_BYTE, 1'b0, 32'h0, 1'b0, 3, 0, 1);
    wait_resp("st_byte");
    tick();
    chk("mem13", 32'(m[0][10'h13]), 32'hA5);
    chk("mem12", 32'(m[0][10'h12]), 32'(pb(10'h12)));
    chk("mem14", 32'(m[0][10'h14]), 32'(pb(10'h14)));
    issue_d(0, 32'h13, 32'h0, 1'b0, SIZE_BYTE, 1'b1, 32'hFFFFFFA5, 1'b0, 3, 2, 0);
    wait_resp("ld_byte_s");
    tick();
    issue_d(0, 32'h13, 32'h0, 1'b0, SIZE_BYTE, 1'b0, 32'h000000A5, 1'b0, 3, 2, 0);
    wait_resp("ld_byte_u");
    tick();
    issue_d(0, 32'h12, 32'h0, 1'b0, SIZE_HALF, 1'b1, {16'hFFFF, 8'hA5, pb(10'h12)}, 1'b0, 3, 2, 0);
    wait_resp("ld_half_s");
    tick();

    // Rejected accesses: two-cycle turnaround, no memory activity.
    issue_d(0, 32'h102, 32'hCAFEF00D, 1'b1, SIZE_WORD, 1'b0, 32'h0, 1'b1, 1, 0, 0);
    wait_resp("st_mis_word");
    tick();
    chk("mem100", {m[0][10'h103], m[0][10'h102], m[0][10'h101], m[0][10'h100]}, exp_w(10'h100));
    issue_d(0, 32'h100, 32'hCAFEF00D, 1'b1, 2'b11, 1'b0, 32'h0, 1'b1, 1, 0, 0);
    wait_resp("st_size11");
    tick();
    chk("mem100b", {m[0][10'h103], m[0][10'h102], m[0][10'h101], m[0][10'h100]}, exp_w(10'h100));
    issue_d(0, 32'h11, 32'h0, 1'b0, SIZE_HALF, 1'b0, 32'h0, 1'b1, 1, 0, 0);
    wait_resp("ld_mis_half");
    tick();
    issue_if(0, 32'h42, 32'h0, 1'b1, 1, 0);
    wait_resp("fetch_mis");
    tick();

    // Both requesting from reset release: IF, D, IF, D.
    if_addr[0] = 32'h40;
    d_addr[0] = 32'h44; d_we[0] = 1'b0; d_size[0] = SIZE_WORD; d_sign[0] = 1'b0;
    if_req[0] = 1'b1;   d_req[0] = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    e = '{inst: 0, is_d: 1'b0, rdata: 32'h8C010004, err: 1'b0, lat: 3, nrd: 2, nwr: 0, drop: 1'b0};
    sb.push_back(e);
    e = '{inst: 0, is_d: 1'b1, rdata: exp_w(10'h44), err: 1'b0, lat: 4, nrd: 2, nwr: 0, drop: 1'b0};
    sb.push_back(e);
    e = '{inst: 0, is_d: 1'b0, rdata: 32'h8C010004, err: 1'b0, lat: 4, nrd: 2, nwr: 0, drop: 1'b0};
    sb.push_back(e);
    e = '{inst: 0, is_d: 1'b1, rdata: exp_w(10'h44), err: 1'b0, lat: 4, nrd: 2, nwr: 0, drop: 1'b1};
    sb.push_back(e);
    wait_resp("rr1_if");
    wait_resp("rr2_d");
    wait_resp("rr3_if");
    wait_resp("rr4_d");
    if_req[0] = 1'b0;
    repeat (3) tick();
    chk("rr_quiet", 32'({if_ready[0], d_ready[0], mem_read[0]}), 32'd0);

    // Reset during the first BUSY cycle of a latency-3 word store.
    wr0 = wr_cnt[1];
    d_addr[1] = 32'h200; d_wdata[1] = 32'hDEADBEEF; d_we[1] = 1'b1;
    d_size[1] = SIZE_WORD; d_sign[1] = 1'b0; d_req[1] = 1'b1;
    tick();
    chk("abort_busy_addr", mem_addr[1], 32'h200);
    rst = 1'b1;
    d_req[1] = 1'b0;
    tick();
    chk("abort_mem_rw",   32'({mem_read[1], mem_write[1]}), 32'd0);
    chk("abort_mem_addr", mem_addr[1], 32'h0);
    chk("abort_mem_din",  mem_din[1],  32'h0);
    chk("abort_mem_ctl",  32'({mem_size[1], mem_sign[1]}), 32'd0);
    chk("abort_ready",    32'({d_ready[1], d_err[1], if_ready[1], if_err[1]}), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_ready", 32'(d_ready[1]), 32'd0);
    end
    chk("abort_writes", wr_cnt[1] - wr0, 0);
    chk("abort_mem200", {m[1][10'h203], m[1][10'h202], m[1][10'h201], m[1][10'h200]}, exp_w(10'h200));

    // Latency 1, back-to-back loads every three cycles.
    issue_d(2, 32'h80, 32'h0, 1'b0, SIZE_WORD, 1'b0, exp_w(10'h80), 1'b0, 2, 1, 0);
    wait_resp("b2b_0");
    issue_d(2, 32'h84, 32'h0, 1'b0, SIZE_WORD, 1'b0, exp_w(10'h84), 1'b0, 3, 1, 0);
    wait_resp("b2b_1");
    issue_d(2, 32'h8A, 32'h0, 1'b0, SIZE_HALF, 1'b0, {16'h0, pb(10'h8B), pb(10'h8A)}, 1'b0, 3, 1, 0);
    wait_resp("b2b_2");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
